// File: rtl/mdu_ctrl.sv
// MDU controller: models mult/div latency with a down-counter and owns HI/LO.
// Optional `define MDU_FLUSH_EN adds a flush input that aborts the operation in flight.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | no operation in flight; mthi/mtlo and new mult/div accepted
  // RUN   | counting down latency; hi/lo hold pre-op values, result in shadow
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [63:0] shadow, shadow_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        kill;

`ifdef MDU_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  logic [63:0] mul_a, mul_b, product;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] op_result;

  always_comb begin
    mul_a   = (op == 3'd0) ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    mul_b   = (op == 3'd0) ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    product = mul_a * mul_b;
  end

  // Signed divide runs on magnitudes so 0x8000_0000 / -1 wraps instead of trapping.
  always_comb begin
    a_neg = (op == 3'd2) & rs_val[31];
    b_neg = (op == 3'd2) & rt_val[31];
    a_mag = a_neg ? -rs_val : rs_val;
    b_mag = b_neg ? -rt_val : rt_val;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
    if (rt_val == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = rs_val;
    end
  end

  assign op_result = op[1] ? {rem, quot} : product;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      shadow <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      shadow <= shadow_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    shadow_nxt = shadow;
    hi_nxt     = hi;
    lo_nxt     = lo;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !kill) begin
          if (!op[2]) begin
            state_nxt  = RUN;
            count_nxt  = op[1] ? DIV_LOAD : MULT_LOAD;
            shadow_nxt = op_result;
          end else if (op == 3'd4) begin
            hi_nxt = rs_val;
          end else if (op == 3'd5) begin
            lo_nxt = rs_val;
          end
        end
      end
      RUN: begin
        if (kill) begin
          state_nxt = IDLE;
          count_nxt = 4'd0;
        end else if (count == 4'd0) begin
          state_nxt = IDLE;
          hi_nxt    = shadow[63:32];
          lo_nxt    = shadow[31:0];
          done      = 1'b1;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
    endcase
  end

  assign busy      = (state == RUN);
  assign stall_req = md_use_d & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected hi/lo and busy length,
// a monitor pops and compares whenever busy falls.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
`ifdef MDU_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    bit          done;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                      input int len, input bit dn);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.len = len; e.done = dn;
    sb.push_back(e);
  endtask

  // Monitor: count busy cycles and done pulses, compare when busy falls.
  initial begin
    int   run_len;
    int   done_cnt;
    bit   last_done;
    bit   prev_busy;
    exp_t e;
    run_len = 0; done_cnt = 0; last_done = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run_len++;
        last_done = (done === 1'b1);
        if (done === 1'b1) done_cnt++;
      end else begin
        if (done !== 1'b0) chk("done_while_idle", 32'(done), 32'd0);
        if (prev_busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, hi, e.hi);
            chk({e.name, "_lo"}, lo, e.lo);
            chk({e.name, "_busy_len"}, 32'(run_len), 32'(e.len));
            chk({e.name, "_done_cnt"}, 32'(done_cnt), e.done ? 32'd1 : 32'd0);
            if (e.done) chk({e.name, "_done_last"}, 32'(last_done), 32'd1);
          end
        end
        run_len = 0; done_cnt = 0; last_done = 1'b0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
    push(name, h, l, o[1] ? 10 : 5, 1'b1);
    issue(o, a, b);
    wait_idle(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; rs_val = 32'd0; rt_val = 32'd0; md_use_d = 1'b0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    md_use_d = 1'b1; #1;
    chk("rst_stall", 32'(stall_req), 32'd0);
    md_use_d = 1'b0;

    // mult 3 * -2 with an MDU instruction in D on the start cycle
    push("mult_3_m2", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'hFFFF_FFFE; md_use_d = 1'b1;
    #1 chk("stall_on_start", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    chk("stall_busy", 32'(stall_req), 32'd1);
    md_use_d = 1'b0; #1;
    chk("stall_no_use", 32'(stall_req), 32'd0);
    wait_idle("mult_3_m2");

    // second start and mtlo during RUN are ignored; hi/lo hold old values
    push("mult_ignore_2nd", 32'd1, 32'd0, 5, 1'b1);
    issue(3'd0, 32'h0001_0000, 32'h0001_0000);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd2; md_use_d = 1'b1;
    #1 chk("stall_busy_2nd", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    op = 3'd5; rs_val = 32'h0000_AAAA; md_use_d = 1'b0;
    #1 chk("stall_busy_mtlo", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    chk("hold_hi_run", hi, 32'hFFFF_FFFF);
    chk("hold_lo_run", lo, 32'hFFFF_FFFA);
    wait_idle("mult_ignore_2nd");

    // mthi / mtlo / no-op in IDLE
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF; md_use_d = 1'b1;
    #1 chk("stall_mthi", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7; md_use_d = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'd0);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF);
    issue(3'd6, 32'h5555_5555, 32'd0);
    chk("nop6_hi", hi, 32'hDEAD_BEEF);
    chk("nop6_lo", lo, 32'h1234_5678);
    chk("nop6_busy", 32'(busy), 32'd0);

    run_op("divu_7_2",      3'd3, 32'd7,          32'd2,          32'd1,          32'd3);
    run_op("div_m7_2",      3'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD);
    run_op("div_7_m2",      3'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD);
    run_op("divu_big_2",    3'd3, 32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC);
    run_op("div_5_0",       3'd2, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF);
    run_op("divu_9_0",      3'd3, 32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF);
    run_op("div_min_m1",    3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);
    run_op("multu_max",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1);
    run_op("div_100_7",     3'd2, 32'd100,        32'd7,          32'd2,          32'd14);

    // reset during cycle 3 of a divide
    push("reset_mid_div", 32'd0, 32'd0, 3, 1'b0);
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_mid_busy", 32'(busy), 32'd0);
    wait_idle("reset_mid_div");

    run_op("mult_m1_m1",    3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1);

`ifdef MDU_FLUSH_EN
    push("flush_mid_div", 32'd0, 32'd1, 3, 1'b0);
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle("flush_mid_div");
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; rs_val = 32'h0000_1234; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7; flush = 1'b0;
    chk("flush_mthi_hi", hi, 32'd0);
    chk("flush_mthi_busy", 32'(busy), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1 chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
